level_sequencer: RTL and testbench

- Frame-synchronous game-flow controller for the VGA text game.
- Decides which screen the text renderers draw: attract, level title, play, pass, fail or win.
- Tracks the current level, lives and the play-time countdown.
- Drives the screen-select mux in front of the per-level display blocks. Applies every screen change only on a frame boundary, so no frame shows two screens (no tearing).

---
 rtl/level_sequencer_pkg.sv | 29 ++
 rtl/level_sequencer_if.sv | 27 ++
 rtl/level_sequencer_frame_timer.sv | 31 +++
 rtl/level_sequencer.sv | 150 +++++++++++++++
 tb/tb_level_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/level_sequencer_pkg.sv
// Shared definitions for the game-flow sequencer and the screen-select mux.
// The screen codes double as the sequencer state encoding.
package level_sequencer_pkg;

  typedef enum logic [2:0] {
    SCR_ATTRACT = 3'd0,
    SCR_TITLE   = 3'd1,
    SCR_PLAY    = 3'd2,
    SCR_PASS    = 3'd3,
    SCR_FAIL    = 3'd4,
    SCR_WIN     = 3'd5
  } screen_e;

  localparam int DEF_NUM_LEVELS    = 3;
  localparam int DEF_MAX_LIVES     = 3;
  localparam int DEF_TITLE_FRAMES  = 120;
  localparam int DEF_RESULT_FRAMES = 90;
  localparam int DEF_PLAY_FRAMES   = 1800;
  localparam int TIME_W            = 12;

  // Narrowest counter that can reach the largest terminal count (at least 1 bit).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Control inputs and status outputs of the game-flow sequencer.
// The master side drives the pulses; the slave side is the sequencer.
interface level_sequencer_if;
  import level_sequencer_pkg::*;

  logic              frame_tick;
  logic              start_btn;
  logic              answer_valid;
  logic              answer_correct;
  logic [2:0]        screen_sel;
  logic [2:0]        level;
  logic [2:0]        lives;
  logic [TIME_W-1:0] time_left;
  logic              answer_en;
  logic              game_over;

  modport master (
    output frame_tick, start_btn, answer_valid, answer_correct,
    input  screen_sel, level, lives, time_left, answer_en, game_over
  );

  modport slave (
    input  frame_tick, start_btn, answer_valid, answer_correct,
    output screen_sel, level, lives, time_left, answer_en, game_over
  );

endinterface

// File: rtl/level_sequencer_frame_timer.sv
// Frame counter for the sequencer: counts ticks, clears on state change and
// reports both the terminal-count hit and the frames remaining before it.
module level_sequencer_frame_timer #(
  parameter int CNT_W = 3,
  parameter int LIM_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clear,
  input  logic [LIM_W-1:0] limit,
  output logic             done,
  output logic [LIM_W-1:0] remaining
);

  logic [CNT_W-1:0] count;

  assign done      = (LIM_W'(count) == (limit - LIM_W'(1)));
  assign remaining = limit - LIM_W'(count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Game-flow controller: picks the screen, tracks level, lives and play time.
// Every screen change lands on a frame_tick so a frame never shows two screens.
module level_sequencer
  import level_sequencer_pkg::*;
#(
  parameter int NUM_LEVELS    = DEF_NUM_LEVELS,
  parameter int MAX_LIVES     = DEF_MAX_LIVES,
  parameter int TITLE_FRAMES  = DEF_TITLE_FRAMES,
  parameter int RESULT_FRAMES = DEF_RESULT_FRAMES,
  parameter int PLAY_FRAMES   = DEF_PLAY_FRAMES
) (
  input  logic               clk,
  input  logic               rst_n,
  level_sequencer_if.slave   bus
);

  localparam int CNT_W = cnt_width(TITLE_FRAMES, RESULT_FRAMES, PLAY_FRAMES);
  localparam logic [2:0]        MAX_L      = 3'(MAX_LIVES);
  localparam logic [2:0]        LAST_LEVEL = 3'(NUM_LEVELS);
  localparam logic [TIME_W-1:0] TITLE_LIM  = TIME_W'(TITLE_FRAMES);
  localparam logic [TIME_W-1:0] RESULT_LIM = TIME_W'(RESULT_FRAMES);
  localparam logic [TIME_W-1:0] PLAY_LIM   = TIME_W'(PLAY_FRAMES);

  screen_e           state;
  screen_e           next_state;
  logic              start_pend;
  logic              ans_pend;
  logic              ans_ok;
  logic [2:0]        screen_sel_q;
  logic [2:0]        level_q;
  logic [2:0]        lives_q;
  logic [TIME_W-1:0] time_left_q;
  logic              answer_en_q;
  logic              game_over_q;

  logic              take_ans;
  logic              take_ok;
  logic              change;
  logic              run;
  logic              at_end;
  logic [TIME_W-1:0] limit;
  logic [TIME_W-1:0] remaining;

  // An answer arriving on the tick itself is consumed by that tick.
  assign take_ans = ans_pend | (bus.answer_valid & answer_en_q);
  assign take_ok  = ans_pend ? ans_ok : bus.answer_correct;
  assign change   = (next_state != state);
  assign run      = state inside {SCR_TITLE, SCR_PLAY, SCR_PASS, SCR_FAIL};

  always_comb begin
    limit = '0;
    case (state)
      SCR_TITLE:          limit = TITLE_LIM;
      SCR_PLAY:           limit = PLAY_LIM;
      SCR_PASS, SCR_FAIL: limit = RESULT_LIM;
      default:            limit = '0;
    endcase
  end

  level_sequencer_frame_timer #(
    .CNT_W (CNT_W),
    .LIM_W (TIME_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (bus.frame_tick & run),
    .clear     (change),
    .limit     (limit),
    .done      (at_end),
    .remaining (remaining)
  );

  always_comb begin
    next_state = state;
    if (bus.frame_tick) begin
      case (state)
        SCR_ATTRACT, SCR_WIN: if (start_pend) next_state = SCR_TITLE;
        SCR_TITLE:            if (at_end) next_state = SCR_PLAY;
        SCR_PLAY: begin
          if (take_ans)    next_state = take_ok ? SCR_PASS : SCR_FAIL;
          else if (at_end) next_state = SCR_FAIL;
        end
        SCR_PASS: if (at_end) next_state = (level_q == LAST_LEVEL) ? SCR_WIN : SCR_TITLE;
        SCR_FAIL: if (at_end) next_state = (lives_q == 3'd0) ? SCR_ATTRACT : SCR_TITLE;
        default:  next_state = SCR_ATTRACT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SCR_ATTRACT;
      screen_sel_q <= SCR_ATTRACT;
      level_q      <= 3'd1;
      lives_q      <= MAX_L;
      time_left_q  <= '0;
      answer_en_q  <= 1'b0;
      game_over_q  <= 1'b0;
      start_pend   <= 1'b0;
      ans_pend     <= 1'b0;
      ans_ok       <= 1'b0;
    end else begin
      state        <= next_state;
      screen_sel_q <= next_state;
      game_over_q  <= 1'b0;
      if (change) begin
        start_pend  <= 1'b0;
        ans_pend    <= 1'b0;
        ans_ok      <= 1'b0;
        answer_en_q <= (next_state == SCR_PLAY);
        time_left_q <= (next_state == SCR_PLAY) ? PLAY_LIM : '0;
        case (next_state)
          SCR_TITLE: begin
            if (state == SCR_PASS) begin
              level_q <= level_q + 3'd1;
            end else if (state == SCR_ATTRACT || state == SCR_WIN) begin
              level_q <= 3'd1;
              lives_q <= MAX_L;
            end
          end
          SCR_FAIL: if (lives_q != 3'd0) lives_q <= lives_q - 3'd1;
          SCR_ATTRACT: begin
            game_over_q <= 1'b1;
            level_q     <= 3'd1;
          end
          default: ;
        endcase
      end else begin
        if (bus.start_btn && (state == SCR_ATTRACT || state == SCR_WIN))
          start_pend <= 1'b1;
        // First answer wins; answer_en drops so later ones are ignored.
        if (bus.answer_valid && answer_en_q) begin
          ans_pend    <= 1'b1;
          ans_ok      <= bus.answer_correct;
          answer_en_q <= 1'b0;
        end
        if (bus.frame_tick && state == SCR_PLAY)
          time_left_q <= remaining - TIME_W'(1);
      end
    end
  end

  assign bus.screen_sel = screen_sel_q;
  assign bus.level      = level_q;
  assign bus.lives      = lives_q;
  assign bus.time_left  = time_left_q;
  assign bus.answer_en  = answer_en_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: a frame-level game model predicts the
// outputs for each driven cycle and the prediction is popped after the edge.
module tb_level_sequencer;
  import level_sequencer_pkg::*;

  localparam int NUM_L   = 2;
  localparam int MAX_L   = 2;
  localparam int TITLE_F = 4;
  localparam int RES_F   = 2;
  localparam int PLAY_F  = 8;

  typedef struct {
    int screen;
    int level;
    int lives;
    int tl;
    int ae;
    int go;
  } exp_t;

  logic clk;
  logic rst_n;
  level_sequencer_if bus();

  exp_t sb[$];
  int checks;
  int failures;

  int m_state, m_level, m_lives, m_cnt, m_go;
  bit m_start, m_ans, m_ok;

  level_sequencer #(
    .NUM_LEVELS    (NUM_L),
    .MAX_LIVES     (MAX_L),
    .TITLE_FRAMES  (TITLE_F),
    .RESULT_FRAMES (RES_F),
    .PLAY_FRAMES   (PLAY_F)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] bench did not finish");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_state = 0; m_level = 1; m_lives = MAX_L; m_cnt = 0; m_go = 0;
    m_start = 0; m_ans = 0; m_ok = 0;
  endtask

  // Game rules at frame granularity, one call per driven clock cycle.
  task automatic modelStep(input bit tick, input bit start, input bit av, input bit ac);
    int nxt;
    m_go = 0;
    if (av && m_state == 2 && !m_ans) begin
      m_ans = 1;
      m_ok  = ac;
    end
    nxt = m_state;
    if (tick) begin
      case (m_state)
        0, 5: if (m_start) nxt = 1;
        1: if (m_cnt == TITLE_F - 1) nxt = 2;
        2: begin
          if (m_ans) nxt = m_ok ? 3 : 4;
          else if (m_cnt == PLAY_F - 1) nxt = 4;
        end
        3: if (m_cnt == RES_F - 1) nxt = (m_level == NUM_L) ? 5 : 1;
        4: if (m_cnt == RES_F - 1) nxt = (m_lives == 0) ? 0 : 1;
        default: nxt = 0;
      endcase
    end
    if (nxt != m_state) begin
      if (nxt == 1 && (m_state == 0 || m_state == 5)) begin
        m_level = 1;
        m_lives = MAX_L;
      end
      if (nxt == 1 && m_state == 3) m_level++;
      if (nxt == 4 && m_lives > 0) m_lives--;
      if (nxt == 0) begin
        m_go = 1;
        m_level = 1;
      end
      m_state = nxt;
      m_cnt = 0;
      m_start = 0;
      m_ans = 0;
      m_ok = 0;
    end else begin
      if (tick && m_state >= 1 && m_state <= 4) m_cnt++;
      if (start && (m_state == 0 || m_state == 5)) m_start = 1;
    end
  endtask

  task automatic applyStimulus(input bit tick, input bit start, input bit av, input bit ac);
    exp_t e;
    exp_t got;
    @(negedge clk);
    bus.frame_tick     = tick;
    bus.start_btn      = start;
    bus.answer_valid   = av;
    bus.answer_correct = ac;
    modelStep(tick, start, av, ac);
    e.screen = m_state;
    e.level  = m_level;
    e.lives  = m_lives;
    e.tl     = (m_state == 2) ? PLAY_F - m_cnt : 0;
    e.ae     = (m_state == 2 && !m_ans) ? 1 : 0;
    e.go     = m_go;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 0, 1);
    end else begin
      got = sb.pop_front();
      checkOutput("screen_sel", int'(bus.screen_sel), got.screen);
      checkOutput("level", int'(bus.level), got.level);
      checkOutput("lives", int'(bus.lives), got.lives);
      checkOutput("time_left", int'(bus.time_left), got.tl);
      checkOutput("answer_en", int'(bus.answer_en), got.ae);
      checkOutput("game_over", int'(bus.game_over), got.go);
    end
    bus.frame_tick     = 1'b0;
    bus.start_btn      = 1'b0;
    bus.answer_valid   = 1'b0;
    bus.answer_correct = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_screen"}, int'(bus.screen_sel), 0);
    checkOutput({tag, "_level"}, int'(bus.level), 1);
    checkOutput({tag, "_lives"}, int'(bus.lives), MAX_L);
    checkOutput({tag, "_time"}, int'(bus.time_left), 0);
    checkOutput({tag, "_ae"}, int'(bus.answer_en), 0);
    checkOutput({tag, "_go"}, int'(bus.game_over), 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus.frame_tick = 1'b0;
    bus.start_btn = 1'b0;
    bus.answer_valid = 1'b0;
    bus.answer_correct = 1'b0;
    rst_n = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] start and title countdown");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    checkOutput("plan_title", int'(bus.screen_sel), 1);
    ticks(4);
    checkOutput("plan_play", int'(bus.screen_sel), 2);
    checkOutput("plan_time8", int'(bus.time_left), 8);

    $display("[TB] first answer wins");
    ticks(3);
    checkOutput("plan_time5", int'(bus.time_left), 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1);
    checkOutput("plan_pass", int'(bus.screen_sel), 3);
    ticks(2);
    checkOutput("plan_level2", int'(bus.level), 2);

    $display("[TB] timeout on level 2");
    ticks(4);
    ticks(8);
    checkOutput("plan_timeout", int'(bus.screen_sel), 4);
    checkOutput("plan_lives1", int'(bus.lives), 1);
    ticks(2);
    checkOutput("plan_retry_title", int'(bus.screen_sel), 1);
    ticks(4);

    $display("[TB] wrong answer on the tick, game over");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("plan_fail_tick", int'(bus.screen_sel), 4);
    checkOutput("plan_lives0", int'(bus.lives), 0);
    ticks(2);
    checkOutput("plan_game_over", int'(bus.game_over), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("plan_go_one_cycle", int'(bus.game_over), 0);

    $display("[TB] full run to win");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(1);
    ticks(2);
    ticks(4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    ticks(2);
    checkOutput("plan_win", int'(bus.screen_sel), 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    checkOutput("plan_restart_title", int'(bus.screen_sel), 1);
    checkOutput("plan_restart_level", int'(bus.level), 1);
    checkOutput("plan_restart_lives", int'(bus.lives), 2);

    $display("[TB] reset mid-play");
    ticks(4);
    ticks(2);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold_go", int'(bus.game_over), 0);
      checkOutput("reset_hold_screen", int'(bus.screen_sel), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
